output_port_scheduler: RTL and testbench
========================================

OUTPUT_PORT_SCHEDULER -- requirements
Module: output_port_scheduler

Interface
REQ-001 Parameter: DEPTH, 4, downstream buffer depth in flits; also the credit counter reset value; range 1..7.
REQ-002 Parameter: STALL_W, 16, stall counter width.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req  input  5  per-input-buffer request for this output port; bit 0=E, 1=W, 2=N, 3=S, 4=INJ; means flit ready.
REQ-006 tail  input  5  per-input flag: the current head flit of that buffer is a tail flit.
REQ-007 credit_ret  input  1  one-cycle pulse; downstream freed one buffer slot.
REQ-008 grant  output  5  registered, one-hot or zero; current owner of the port.
REQ-009 flit_send  output  1  combinational; flit transferred this cycle.
REQ-010 busy  output  1  registered; port locked to an owner.
REQ-011 credits  output  3  registered; available downstream slots.
REQ-012 credit_err  output  1  registered, sticky; credit overflow seen.
REQ-013 stall_cnt  output  STALL_W  registered; credit-stall cycle count.

Function
REQ-014 FSM states: IDLE, LOCKED; busy SHALL be 1 exactly in LOCKED.
REQ-015 In IDLE with req!=0, the block SHALL pick the first set req bit at or after rr_ptr, scanning cyclically upward (4 wraps to 0), load owner, and enter LOCKED next cycle with grant[owner]=1.
REQ-016 In IDLE with req==0, state, grant (0) and rr_ptr SHALL hold.
REQ-017 In LOCKED, flit_send SHALL equal req[owner] AND (credits!=0); it SHALL be 0 in IDLE.
REQ-018 A flit_send with tail[owner]=1 SHALL return the FSM to IDLE next cycle, clear grant, and set rr_ptr to (owner+1) mod 5.
REQ-019 Deassertion of req[owner] while LOCKED SHALL NOT release the lock; wormhole hold until tail is sent.
REQ-020 Minimum turnaround: tail sent in cycle t, next grant visible no earlier than t+2.
REQ-021 Credits update: -1 on flit_send, +1 on credit_ret, unchanged when both occur in the same cycle.
REQ-022 flit_send SHALL use the pre-update credit value; credits==0 plus credit_ret blocks the send that cycle, and credits becomes 1.
REQ-023 A credit_ret that would exceed DEPTH (without a simultaneous send) SHALL be dropped, credits held at DEPTH, and credit_err set to 1 until reset.
REQ-024 Requests from non-owners while LOCKED SHALL be ignored.

Reset
REQ-025 On reset: state=IDLE, grant=0, busy=0, rr_ptr=0, owner=0, credits=DEPTH, credit_err=0, stall_cnt=0.
REQ-026 Reset mid-packet SHALL abandon the lock with no flit_send in the reset cycle; no state is retained.

Configuration
REQ-027 Macro SCHED_STALL_CNT_EN defined: stall_cnt SHALL increment by 1 in each cycle with LOCKED AND req[owner] AND credits==0, saturating at all-ones.
REQ-028 Macro SCHED_STALL_CNT_EN undefined: stall_cnt SHALL be tied to 0, the port SHALL remain present, and no counter logic SHALL be synthesized.

Structure
REQ-029 Shared package noc_pkg SHALL hold NUM_PORTS=5, port index constants E/W/N/S/INJ, and the scheduler state enum.
REQ-030 Sub-module rr_arbiter5 (combinational: req, rr_ptr -> one-hot pick, valid) SHALL implement REQ-015.

Verification
REQ-031 After reset, req=00101 and rr_ptr=0 -> grant=00001 next cycle; E sends 3 flits with tail on the 3rd -> credits 4->1, then grant=0, and rr_ptr=1.
REQ-032 With rr_ptr=1 and req=00101 held -> grant=00100 (N) next; after N sends its tail, E is granted; full cycle order is fair.
REQ-033 Locked with credits=0, req[owner]=1 for 5 cycles, then a credit_ret pulse -> flit_send=0 for 5 cycles, stall_cnt=5 (macro on) or 0 (macro off), then send resumes one cycle after the pulse.
REQ-034 credits=DEPTH and credit_ret without send -> credits stays 4 and credit_err=1 sticky; simultaneous send+credit_ret at credits=2 -> credits stays 2.
REQ-035 Reset asserted mid-packet (owner=S, credits=1) -> next cycle grant=0, busy=0, credits=4, rr_ptr=0.
REQ-036 Owner is INJ (4) and sends its tail -> rr_ptr wraps to 0; with req=11111, E is granted next.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: port count, port indices and scheduler state encoding.
package noc_pkg;

  localparam int NUM_PORTS = 5;

  localparam int E   = 0;
  localparam int W   = 1;
  localparam int N   = 2;
  localparam int S   = 3;
  localparam int INJ = 4;

  typedef enum logic {
    SCHED_IDLE   = 1'b0,
    SCHED_LOCKED = 1'b1
  } sched_state_e;

  function automatic logic [2:0] onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [2:0] next_port(input logic [2:0] p);
    return (p == 3'(NUM_PORTS - 1)) ? 3'd0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter5.sv
// Combinational round-robin pick over five requesters, starting the scan at rr_ptr_i.
// Zero latency; the pick is only a proposal, so there is no backpressure here.
module rr_arbiter5
  import noc_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [2:0]           rr_ptr_i,
  output logic [NUM_PORTS-1:0] pick_o,
  output logic                 valid_o
);

  logic [3:0] pos;

  // Walk from the farthest candidate back to rr_ptr_i so the nearest set bit wins.
  always_comb begin
    pick_o = '0;
    pos    = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      pos = {1'b0, rr_ptr_i} + 4'(k);
      if (pos >= 4'(NUM_PORTS)) pos = pos - 4'(NUM_PORTS);
      if (req_i[pos[2:0]]) begin
        pick_o             = '0;
        pick_o[pos[2:0]]   = 1'b1;
      end
    end
    valid_o = |req_i;
  end

endmodule

// File: rtl/output_port_scheduler.sv
// Wormhole output-port scheduler: round-robin lock per packet, credit-gated flit send.
// Optional stall counter enabled by macro SCHED_STALL_CNT_EN; otherwise stall_cnt reads 0.
module output_port_scheduler
  import noc_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         req,
  input  logic [4:0]         tail,
  input  logic               credit_ret,
  output logic [4:0]         grant,
  output logic               flit_send,
  output logic               busy,
  output logic [2:0]         credits,
  output logic               credit_err,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  sched_state_e         state_q, state_d;
  logic [2:0]           owner_q, owner_d;
  logic [2:0]           rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [2:0]           credits_q, credits_d;
  logic                 credit_err_q, credit_err_d;

  logic [NUM_PORTS-1:0] arb_pick;
  logic                 arb_vld;

  rr_arbiter5 u_arb (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .pick_o   (arb_pick),
    .valid_o  (arb_vld)
  );

  // Send is suppressed in a reset cycle so an abandoned packet cannot leak a flit.
  assign flit_send = !reset && (state_q == SCHED_LOCKED) && req[owner_q] && (credits_q != 3'd0);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    case (state_q)
      SCHED_IDLE: begin
        if (arb_vld) begin
          state_d = SCHED_LOCKED;
          owner_d = onehot_to_idx(arb_pick);
          grant_d = arb_pick;
        end
      end
      SCHED_LOCKED: begin
        if (flit_send && tail[owner_q]) begin
          state_d  = SCHED_IDLE;
          grant_d  = '0;
          rr_ptr_d = next_port(owner_q);
        end
      end
      default: state_d = SCHED_IDLE;
    endcase
  end

  // A lone return at full credit means downstream miscounted: drop it and flag.
  always_comb begin
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    if (flit_send && !credit_ret) begin
      credits_d = credits_q - 3'd1;
    end else if (credit_ret && !flit_send) begin
      if (credits_q == DEPTH_C) credit_err_d = 1'b1;
      else                      credits_d    = credits_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SCHED_IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      credits_q    <= DEPTH_C;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign grant      = grant_q;
  assign busy       = (state_q == SCHED_LOCKED);
  assign credits    = credits_q;
  assign credit_err = credit_err_q;

`ifdef SCHED_STALL_CNT_EN
  logic [STALL_W-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if ((state_q == SCHED_LOCKED) && req[owner_q] && (credits_q == 3'd0)
                 && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_output_port_scheduler.sv
// Bench for output_port_scheduler: directed scenarios plus a randomized run against a rule-level model.
module tb_output_port_scheduler;

  localparam int DEPTH   = 4;
  localparam int STALL_W = 16;
`ifdef SCHED_STALL_CNT_EN
  localparam int EXP_STALL5 = 5;
  localparam bit STALL_ON   = 1'b1;
`else
  localparam int EXP_STALL5 = 0;
  localparam bit STALL_ON   = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic [4:0]         req, tail;
  logic               credit_ret;
  logic [4:0]         grant;
  logic               flit_send, busy, credit_err;
  logic [2:0]         credits;
  logic [STALL_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state, expressed directly in terms of the port rules.
  bit m_locked, m_err, m_send;
  int m_owner, m_rr, m_cred, m_stall;

  always #5 clk = ~clk;

  output_port_scheduler #(.DEPTH(DEPTH), .STALL_W(STALL_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .tail       (tail),
    .credit_ret (credit_ret),
    .grant      (grant),
    .flit_send  (flit_send),
    .busy       (busy),
    .credits    (credits),
    .credit_err (credit_err),
    .stall_cnt  (stall_cnt)
  );

  function automatic logic [4:0] m_grant();
    logic [4:0] g;
    g = '0;
    if (m_locked) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic drive(input logic [4:0] r, input logic [4:0] t, input logic cr, input logic rs);
    req = r; tail = t; credit_ret = cr; reset = rs;
    @(negedge clk);
    m_send = !rs && m_locked && r[m_owner] && (m_cred != 0);
  endtask

  task automatic tick();
    bit nl, ne;
    int no, nr, nc, ns, idx;
    nl = m_locked; ne = m_err; no = m_owner; nr = m_rr; nc = m_cred; ns = m_stall;
    if (reset) begin
      nl = 0; ne = 0; no = 0; nr = 0; nc = DEPTH; ns = 0;
    end else begin
      if (!m_locked) begin
        for (int k = 0; k < 5; k++) begin
          idx = (m_rr + k) % 5;
          if (req[idx]) begin nl = 1; no = idx; break; end
        end
      end else if (m_send && tail[m_owner]) begin
        nl = 0; nr = (m_owner + 1) % 5;
      end
      if (m_send && !credit_ret) nc = nc - 1;
      else if (credit_ret && !m_send) begin
        if (m_cred == DEPTH) ne = 1; else nc = nc + 1;
      end
      if (STALL_ON && m_locked && req[m_owner] && m_cred == 0 && m_stall < (1 << STALL_W) - 1)
        ns = ns + 1;
    end
    @(posedge clk); #1;
    m_locked = nl; m_err = ne; m_owner = no; m_rr = nr; m_cred = nc; m_stall = ns;
  endtask

  task automatic test_reset();
    drive(5'b0, 5'b0, 1'b0, 1'b1); tick();
    drive(5'b0, 5'b0, 1'b0, 1'b1); tick();
    checks++; if (grant !== 5'b0) begin errors++; $display("FAIL reset_grant got %b want %b", grant, 5'b0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (credits !== 3'd4) begin errors++; $display("FAIL reset_credits got %0d want 4", credits); end
    checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", credit_err); end
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
  endtask

  task automatic test_basic_packet();
    drive(5'b00101, 5'b0, 1'b0, 1'b0);
    checks++; if (flit_send !== 1'b0) begin errors++; $display("FAIL idle_send got %b want 0", flit_send); end
    tick();
    checks++; if (grant !== 5'b00001) begin errors++; $display("FAIL first_grant got %b want 00001", grant); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_busy got %b want 1", busy); end
    for (int k = 0; k < 3; k++) begin
      drive(5'b00101, (k == 2) ? 5'b00001 : 5'b0, 1'b0, 1'b0);
      checks++; if (flit_send !== 1'b1) begin errors++; $display("FAIL e_send%0d got %b want 1", k, flit_send); end
      tick();
    end
    checks++; if (credits !== 3'd1) begin errors++; $display("FAIL e_credits got %0d want 1", credits); end
    checks++; if (grant !== 5'b0) begin errors++; $display("FAIL e_release got %b want 00000", grant); end
  endtask

  task automatic test_fairness();
    drive(5'b00101, 5'b0, 1'b0, 1'b0); tick();
    checks++; if (grant !== 5'b00100) begin errors++; $display("FAIL rr_n_grant got %b want 00100", grant); end
    drive(5'b00101, 5'b00100, 1'b0, 1'b0);
    checks++; if (flit_send !== 1'b1) begin errors++; $display("FAIL n_tail_send got %b want 1", flit_send); end
    tick();
    checks++; if (grant !== 5'b0) begin errors++; $display("FAIL turnaround got %b want 00000", grant); end
    drive(5'b00101, 5'b0, 1'b0, 1'b0); tick();
    checks++; if (grant !== 5'b00001) begin errors++; $display("FAIL rr_e_grant got %b want 00001", grant); end
  endtask

  task automatic test_credit_stall();
    for (int k = 0; k < 5; k++) begin
      drive(5'b00101, 5'b0, 1'b0, 1'b0);
      checks++; if (flit_send !== 1'b0) begin errors++; $display("FAIL stall_send%0d got %b want 0", k, flit_send); end
      tick();
    end
    checks++; if (stall_cnt !== STALL_W'(EXP_STALL5)) begin errors++; $display("FAIL stall_cnt got %0d want %0d", stall_cnt, EXP_STALL5); end
    drive(5'b00101, 5'b0, 1'b1, 1'b0);
    checks++; if (flit_send !== 1'b0) begin errors++; $display("FAIL zero_credit_ret_send got %b want 0", flit_send); end
    tick();
    checks++; if (credits !== 3'd1) begin errors++; $display("FAIL credit_back got %0d want 1", credits); end
    drive(5'b00101, 5'b00001, 1'b0, 1'b0);
    checks++; if (flit_send !== 1'b1) begin errors++; $display("FAIL resume_send got %b want 1", flit_send); end
    tick();
  endtask

  task automatic test_credit_overflow();
    for (int k = 0; k < 4; k++) begin drive(5'b0, 5'b0, 1'b1, 1'b0); tick(); end
    checks++; if (credits !== 3'd4 || credit_err !== 1'b0) begin errors++; $display("FAIL refill got %0d/%b want 4/0", credits, credit_err); end
    drive(5'b0, 5'b0, 1'b1, 1'b0); tick();
    checks++; if (credits !== 3'd4 || credit_err !== 1'b1) begin errors++; $display("FAIL overflow got %0d/%b want 4/1", credits, credit_err); end
    drive(5'b00010, 5'b0, 1'b0, 1'b0); tick();
    checks++; if (grant !== 5'b00010) begin errors++; $display("FAIL w_grant got %b want 00010", grant); end
    drive(5'b00010, 5'b0, 1'b0, 1'b0); tick();
    drive(5'b00010, 5'b0, 1'b0, 1'b0); tick();
    drive(5'b00010, 5'b0, 1'b1, 1'b0);
    checks++; if (flit_send !== 1'b1) begin errors++; $display("FAIL sim_send got %b want 1", flit_send); end
    tick();
    checks++; if (credits !== 3'd2) begin errors++; $display("FAIL send_plus_ret got %0d want 2", credits); end
    checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", credit_err); end
    drive(5'b00010, 5'b00010, 1'b0, 1'b0); tick();
  endtask

  task automatic test_reset_mid_packet();
    drive(5'b01000, 5'b0, 1'b0, 1'b0); tick();
    checks++; if (grant !== 5'b01000 || credits !== 3'd1) begin errors++; $display("FAIL s_lock got %b/%0d want 01000/1", grant, credits); end
    drive(5'b01000, 5'b0, 1'b0, 1'b1);
    checks++; if (flit_send !== 1'b0) begin errors++; $display("FAIL reset_cycle_send got %b want 0", flit_send); end
    tick();
    checks++; if (grant !== 5'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset got %b/%b want 00000/0", grant, busy); end
    checks++; if (credits !== 3'd4 || credit_err !== 1'b0) begin errors++; $display("FAIL mid_reset_cred got %0d/%b want 4/0", credits, credit_err); end
    drive(5'b00110, 5'b0, 1'b0, 1'b0); tick();
    checks++; if (grant !== 5'b00010) begin errors++; $display("FAIL rr_after_reset got %b want 00010", grant); end
    drive(5'b00110, 5'b00010, 1'b0, 1'b0); tick();
  endtask

  task automatic test_inj_wrap();
    drive(5'b10000, 5'b0, 1'b0, 1'b0); tick();
    checks++; if (grant !== 5'b10000) begin errors++; $display("FAIL inj_grant got %b want 10000", grant); end
    drive(5'b10000, 5'b10000, 1'b0, 1'b0); tick();
    drive(5'b11111, 5'b0, 1'b0, 1'b0); tick();
    checks++; if (grant !== 5'b00001) begin errors++; $display("FAIL wrap_grant got %b want 00001", grant); end
  endtask

  task automatic test_random();
    logic [4:0] r, t;
    logic cr, rs;
    drive(5'b0, 5'b0, 1'b0, 1'b1); tick();
    for (int n = 0; n < 3000; n++) begin
      r  = 5'($urandom);
      t  = 5'($urandom) & 5'($urandom);
      cr = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 199) == 0);
      drive(r, t, cr, rs);
      checks++; if (flit_send !== m_send) begin errors++; $display("FAIL rnd_send @%0d got %b want %b", n, flit_send, m_send); end
      tick();
      checks++; if (grant !== m_grant()) begin errors++; $display("FAIL rnd_grant @%0d got %b want %b", n, grant, m_grant()); end
      checks++; if (busy !== m_locked) begin errors++; $display("FAIL rnd_busy @%0d got %b want %b", n, busy, m_locked); end
      checks++; if (credits !== 3'(m_cred)) begin errors++; $display("FAIL rnd_credits @%0d got %0d want %0d", n, credits, m_cred); end
      checks++; if (credit_err !== m_err) begin errors++; $display("FAIL rnd_err @%0d got %b want %b", n, credit_err, m_err); end
      checks++; if (stall_cnt !== STALL_W'(m_stall)) begin errors++; $display("FAIL rnd_stall @%0d got %0d want %0d", n, stall_cnt, m_stall); end
    end
  endtask

  initial begin
    req = '0; tail = '0; credit_ret = 1'b0; reset = 1'b1;
    m_locked = 0; m_err = 0; m_send = 0; m_owner = 0; m_rr = 0; m_cred = DEPTH; m_stall = 0;
    test_reset();
    test_basic_packet();
    test_fairness();
    test_credit_stall();
    test_credit_overflow();
    test_reset_mid_packet();
    test_inj_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
